// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the 5-stage core's branch path.
//   - br_type_e : conditional-branch compare codes carried into ID
//   - bru_state_e : branch resolve unit squash FSM states
//   - INSTR_BYTES : fetch step used to form the fall-through PC
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        BR_BEQ = 2'd0,
        BR_BNE = 2'd1,
        BR_BLT = 2'd2,
        BR_BGE = 2'd3
    } br_type_e;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_SQUASH = 1'b1
    } bru_state_e;

    localparam int INSTR_BYTES = 4;

endpackage : core_pkg

// File: rtl/br_cmp.sv
// ----------------------------------------------------------------------------
// br_cmp
//   Pure combinational branch comparator. Produces the real branch direction
//   for the instruction in ID.
//   Ports:
//     br_type  in  2   compare select (BEQ/BNE/BLT/BGE, BLT/BGE signed)
//     rs1      in  DW  operand 1 (forwarded)
//     rs2      in  DW  operand 2 (forwarded)
//     actual   out 1   1 = branch taken
// ----------------------------------------------------------------------------
module br_cmp
    import core_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    br_type,
    input  logic [DW-1:0] rs1,
    input  logic [DW-1:0] rs2,
    output logic          actual
);

    logic eq;
    logic lt;

    assign eq = (rs1 == rs2);
    assign lt = ($signed(rs1) < $signed(rs2));

    always_comb begin
        actual = 1'b0;
        case (br_type_e'(br_type))
            BR_BEQ:  actual = eq;
            BR_BNE:  actual = ~eq;
            BR_BLT:  actual = lt;
            BR_BGE:  actual = ~lt;
            default: actual = 1'b0;
        endcase
    end

endmodule : br_cmp

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//   ID-stage branch resolver for the 5-stage core. Captures each IF branch
//   with its BrPred3 prediction, evaluates the real outcome in ID, feeds the
//   predictor (id_branch / br_wrong) and issues the IF flush plus fetch
//   redirect on a misprediction.
//
//   Optional feature macro: BRU_PERF_CNT_EN
//     defined   : perf_br_cnt / perf_miss_cnt are 32-bit wrapping counters
//     undefined : both ports are constant 0 and no counter flops exist
//
//   Handshake: there is no valid/ready pair here. id_branch is a one-cycle
//   strobe meaning "a branch resolved this cycle"; br_wrong/redirect_valid
//   are only ever high together with it, and the fetch stage must consume
//   redirect_pc at the edge ending that same cycle. stall freezes everything.
//
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     stall            hazard-unit stall, freezes ID capture and FSM
//     if_branch        IF instruction is a conditional branch
//     if_pred_taken    predicted direction of the IF instruction
//     if_pc, if_target PC and branch target of the IF instruction
//     id_rs1, id_rs2   forwarded ID operands
//     id_br_type       compare select for the ID branch
//     id_branch        branch resolving in ID (predictor ID_branch)
//     br_wrong         misprediction in ID (predictor wrong)
//     flush            squash the IF instruction this cycle
//     redirect_valid   fetch loads redirect_pc at the next edge
//     redirect_pc      corrected fetch PC
//     perf_br_cnt      resolved-branch count
//     perf_miss_cnt    misprediction count
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import core_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          if_branch,
    input  logic          if_pred_taken,
    input  logic [AW-1:0] if_pc,
    input  logic [AW-1:0] if_target,
    input  logic [DW-1:0] id_rs1,
    input  logic [DW-1:0] id_rs2,
    input  logic [1:0]    id_br_type,
    output logic          id_branch,
    output logic          br_wrong,
    output logic          flush,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc,
    output logic [31:0]   perf_br_cnt,
    output logic [31:0]   perf_miss_cnt
);

    // ID register
    logic          vld;
    logic          pred;
    logic [AW-1:0] pc;
    logic [AW-1:0] target;

    bru_state_e    state;
    logic          actual;

    br_cmp #(.DW(DW)) u_br_cmp (
        .br_type (id_br_type),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .actual  (actual)
    );

    assign id_branch = vld & ~stall;

    // The squash cycle can never hold a real branch; masking here keeps the
    // predictor from being trained by a wrong-path slot.
    assign br_wrong       = id_branch & (actual ^ pred) & (state == S_RUN);
    assign redirect_valid = br_wrong;
    assign flush          = br_wrong | ((state == S_SQUASH) & ~stall);

    // Gated so the port reads 0 whenever no redirect is requested.
    assign redirect_pc = br_wrong ? (actual ? target : pc + AW'(INSTR_BYTES))
                                  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld    <= 1'b0;
            pred   <= 1'b0;
            pc     <= '0;
            target <= '0;
            state  <= S_RUN;
        end else if (!stall) begin
            vld    <= if_branch & ~flush;
            pred   <= if_pred_taken;
            pc     <= if_pc;
            target <= if_target;
            case (state)
                S_RUN:    if (br_wrong) state <= S_SQUASH;
                S_SQUASH: state <= S_RUN;
                default:  state <= S_RUN;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (id_branch) br_cnt_q   <= br_cnt_q + 32'd1;
            if (br_wrong)  miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_br_cnt   = br_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`else
    assign perf_br_cnt   = 32'd0;
    assign perf_miss_cnt = 32'd0;
`endif

endmodule : branch_resolve_unit

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Self-checking bench for branch_resolve_unit: reference model, fixed vector
//   table, hand-written stall / reset / counter sequences, random traffic.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        if_branch;
    logic        if_pred_taken;
    logic [31:0] if_pc;
    logic [31:0] if_target;
    logic [31:0] id_rs1;
    logic [31:0] id_rs2;
    logic [1:0]  id_br_type;
    logic        id_branch;
    logic        br_wrong;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_miss_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_branch      (if_branch),
        .if_pred_taken  (if_pred_taken),
        .if_pc          (if_pc),
        .if_target      (if_target),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_br_type     (id_br_type),
        .id_branch      (id_branch),
        .br_wrong       (br_wrong),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_br_cnt    (perf_br_cnt),
        .perf_miss_cnt  (perf_miss_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A pending branch waiting in ID, and whether the next slot is wrong-path.
    typedef struct {
        bit          valid;
        bit          pred;
        logic [31:0] pc;
        logic [31:0] tgt;
    } pend_t;

    pend_t       m_pend;
    bit          m_wrong_path;
    int unsigned m_br_cnt;
    int unsigned m_miss_cnt;

    function automatic bit taken(input logic [1:0] bt, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (bt)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return sa < sb;
            default: return sa >= sb;
        endcase
    endfunction

    // Samples of the last cycle, for hand-written checks
    logic        s_idb, s_wrong, s_flush, s_rv;
    logic [31:0] s_rpc;

    // ---------------- driver ----------------
    // Drives one cycle, checks every output against the model at the falling
    // edge, then advances the model at the rising edge.
    task automatic cycle(input bit rst, input bit stl, input bit ib, input bit ip,
                         input logic [31:0] ipc, input logic [31:0] itgt,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [1:0] bt);
        bit          e_idb, e_wrong, e_flush, act;
        logic [31:0] e_rpc;
        rst_n         = ~rst;
        stall         = stl;
        if_branch     = ib;
        if_pred_taken = ib & ip;
        if_pc         = ipc;
        if_target     = itgt;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_br_type    = bt;
        @(negedge clk);
        act     = taken(bt, rs1, rs2);
        e_idb   = m_pend.valid && !stl;
        e_wrong = e_idb && (act != m_pend.pred) && !m_wrong_path;
        e_flush = e_wrong || (m_wrong_path && !stl);
        e_rpc   = !e_wrong ? 32'd0 : (act ? m_pend.tgt : m_pend.pc + 32'd4);
        s_idb = id_branch; s_wrong = br_wrong; s_flush = flush;
        s_rv = redirect_valid; s_rpc = redirect_pc;
        chk("id_branch", {31'd0, id_branch}, {31'd0, e_idb});
        chk("br_wrong", {31'd0, br_wrong}, {31'd0, e_wrong});
        chk("flush", {31'd0, flush}, {31'd0, e_flush});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_wrong});
        chk("redirect_pc", redirect_pc, e_rpc);
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_cnt", perf_br_cnt, m_br_cnt);
        chk("perf_miss_cnt", perf_miss_cnt, m_miss_cnt);
`else
        chk("perf_br_cnt", perf_br_cnt, 32'd0);
        chk("perf_miss_cnt", perf_miss_cnt, 32'd0);
`endif
        @(posedge clk);
        if (rst) begin
            m_pend       = '{0, 0, 32'd0, 32'd0};
            m_wrong_path = 0;
            m_br_cnt     = 0;
            m_miss_cnt   = 0;
        end else begin
            if (e_idb)   m_br_cnt++;
            if (e_wrong) m_miss_cnt++;
            if (!stl) begin
                m_pend       = '{ib && !e_flush, ib && ip, ipc, itgt};
                m_wrong_path = e_wrong;
            end
        end
        #1;
    endtask

    task automatic idle(input bit stl);
        cycle(0, stl, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  bt;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        e_wrong;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        m_pend = '{0, 0, 32'd0, 32'd0};
        m_wrong_path = 0; m_br_cnt = 0; m_miss_cnt = 0;

        vecs[0] = '{2'd0, 32'd5,        32'd1,        1'b0, 32'h100,      32'h140, 1'b0, 32'h0};
        vecs[0] = '{2'd0, 32'd5,        32'd5,        1'b0, 32'h100,      32'h140, 1'b1, 32'h140};
        vecs[1] = '{2'd1, 32'd3,        32'd3,        1'b1, 32'h200,      32'h280, 1'b1, 32'h204};
        vecs[2] = '{2'd2, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h300,      32'h340, 1'b0, 32'h0};
        vecs[3] = '{2'd3, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h400,      32'h480, 1'b1, 32'h404};
        vecs[4] = '{2'd3, 32'd7,        32'd7,        1'b0, 32'h500,      32'h520, 1'b1, 32'h520};
        vecs[5] = '{2'd2, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h600,      32'h6F0, 1'b1, 32'h6F0};
        vecs[6] = '{2'd0, 32'd1,        32'd2,        1'b0, 32'hFFFFFFFC, 32'h10,  1'b0, 32'h0};
        vecs[7] = '{2'd1, 32'd1,        32'd2,        1'b0, 32'hFFFFFFFC, 32'h10,  1'b1, 32'h10};
        vecs[8] = '{2'd0, 32'd1,        32'd2,        1'b1, 32'hFFFFFFFC, 32'h10,  1'b1, 32'h0};

        // ---- reset state ----
        cycle(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0);
        cycle(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0);
        idle(0);
        chk("reset_id_branch", {31'd0, s_idb}, 32'd0);
        chk("reset_flush", {31'd0, s_flush}, 32'd0);
        chk("reset_redirect_pc", s_rpc, 32'd0);

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            cycle(0, 0, 1, vecs[i].pred, vecs[i].pc, vecs[i].tgt, 32'd0, 32'd0, 2'd0);
            cycle(0, 0, 0, 0, 32'd0, 32'd0, vecs[i].rs1, vecs[i].rs2, vecs[i].bt);
            chk($sformatf("vec%0d_id_branch", i), {31'd0, s_idb}, 32'd1);
            chk($sformatf("vec%0d_br_wrong", i), {31'd0, s_wrong}, {31'd0, vecs[i].e_wrong});
            chk($sformatf("vec%0d_flush", i), {31'd0, s_flush}, {31'd0, vecs[i].e_wrong});
            chk($sformatf("vec%0d_redirect_pc", i), s_rpc, vecs[i].e_rpc);
            // wrong-path slot: a branch in IF here must be squashed
            cycle(0, 0, 1, 1, 32'hDEAD0000, 32'hBEEF0000, 32'd0, 32'd0, 2'd0);
            chk($sformatf("vec%0d_squash", i), {31'd0, s_flush}, {31'd0, vecs[i].e_wrong});
            idle(0);
            chk($sformatf("vec%0d_after_id_branch", i), {31'd0, s_idb}, {31'd0, ~vecs[i].e_wrong});
            idle(0);
        end

        // ---- stall held 3 cycles over a mispredicted branch ----
        cycle(0, 0, 1, 0, 32'h700, 32'h780, 32'd0, 32'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, 0, 32'd0, 32'd0, 32'd9, 32'd9, 2'd0);
            chk($sformatf("stall%0d_id_branch", k), {31'd0, s_idb}, 32'd0);
            chk($sformatf("stall%0d_br_wrong", k), {31'd0, s_wrong}, 32'd0);
            chk($sformatf("stall%0d_flush", k), {31'd0, s_flush}, 32'd0);
        end
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 32'd9, 32'd9, 2'd0);
        chk("stall_release_wrong", {31'd0, s_wrong}, 32'd1);
        chk("stall_release_rpc", s_rpc, 32'h780);
        // stall inside the squash cycle: flush waits, then fires once
        cycle(0, 1, 1, 0, 32'h800, 32'h880, 32'd0, 32'd0, 2'd0);
        chk("squash_stalled_flush", {31'd0, s_flush}, 32'd0);
        cycle(0, 0, 1, 0, 32'h800, 32'h880, 32'd0, 32'd0, 2'd0);
        chk("squash_flush", {31'd0, s_flush}, 32'd1);
        idle(0);
        chk("squash_dropped", {31'd0, s_idb}, 32'd0);
        chk("squash_done", {31'd0, s_flush}, 32'd0);

        // ---- reset asserted mid-squash ----
        cycle(0, 0, 1, 0, 32'h900, 32'h940, 32'd0, 32'd0, 2'd0);
        cycle(0, 0, 1, 1, 32'hA00, 32'hA40, 32'd4, 32'd4, 2'd0);
        chk("pre_rst_wrong", {31'd0, s_wrong}, 32'd1);
        cycle(1, 1, 1, 1, 32'hB00, 32'hB40, 32'd4, 32'd4, 2'd0);
        cycle(0, 0, 0, 0, 32'd0, 32'd0, 32'd4, 32'd4, 2'd1);
        chk("rst_sq_id_branch", {31'd0, s_idb}, 32'd0);
        chk("rst_sq_flush", {31'd0, s_flush}, 32'd0);
        chk("rst_sq_redirect", {31'd0, s_rv}, 32'd0);
        chk("rst_sq_redirect_pc", s_rpc, 32'd0);

        // ---- counters: 10 branches, 3 mispredicted ----
        cycle(1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 1, (k >= 3), 32'h1000 + k * 16, 32'h2000, 32'd0, 32'd0, 2'd0);
            cycle(0, 0, 0, 0, 32'd0, 32'd0, 32'd5, 32'd5, 2'd0);
            idle(0);
        end
        idle(0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_10_br", perf_br_cnt, 32'd10);
        chk("perf_3_miss", perf_miss_cnt, 32'd3);
`else
        chk("perf_off_br", perf_br_cnt, 32'd0);
        chk("perf_off_miss", perf_miss_cnt, 32'd0);
`endif

        // ---- random traffic against the model ----
        for (int k = 0; k < 600; k++) begin
            logic [31:0] pool[4];
            pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFFFFFF; pool[3] = 32'h80000000;
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  $urandom, $urandom,
                  pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                  2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_branch_resolve_unit
